// File: rtl/router_pkg.sv
// Shared types and constants for the single-channel packet router.
package router_pkg;

    localparam int DEPTH_DEFAULT = 16;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_PARITY  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        PAYLOAD = ST_PAYLOAD,
        PARITY  = ST_PARITY
    } wr_state_t;

    function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [7:0] parity_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Byte FIFO with extra-MSB pointers for full/empty and a registered read port.
module router_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [7:0]  mem_r [DEPTH];
    logic [7:0]  rd_data_r;
    logic        do_push_s;
    logic        do_pop_s;

    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);

    // Requests against full/empty are dropped, so a push into an empty FIFO never pops.
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = rd_data_r;

    // Pointer and output register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            rd_data_r <= 8'h00;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r  <= rd_ptr_r + (AW+1)'(1);
                rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
            end
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/router_core.sv
// Packet router core: header/payload/parity parser in front of a byte FIFO.
module router_core
    import router_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       pkt_valid,
    output logic       busy,
    output logic       error,
    input  logic       read_enb,
    output logic [7:0] data_out,
    output logic       valid_out
);

    wr_state_t  state_r;
    wr_state_t  state_nxt_s;
    logic [5:0] len_r;
    logic [5:0] len_nxt_s;
    logic [7:0] acc_r;
    logic [7:0] acc_nxt_s;
    logic       error_r;
    logic       error_nxt_s;
    logic       accept_s;
    logic       full_s;
    logic       empty_s;

    assign accept_s  = pkt_valid && !full_s;
    assign busy      = full_s;
    assign valid_out = !empty_s;
    assign error     = error_r;

    // Write-side parser next-state logic
    always_comb begin
        state_nxt_s = state_r;
        len_nxt_s   = len_r;
        acc_nxt_s   = acc_r;
        error_nxt_s = error_r;
        if (accept_s) begin
            case (state_r)
                IDLE: begin
                    len_nxt_s   = hdr_len(data_in);
                    acc_nxt_s   = data_in;
                    state_nxt_s = (hdr_len(data_in) == 6'd0) ? PARITY : PAYLOAD;
                end
                PAYLOAD: begin
                    acc_nxt_s   = parity_next(acc_r, data_in);
                    len_nxt_s   = len_r - 6'd1;
                    state_nxt_s = (len_r == 6'd1) ? PARITY : PAYLOAD;
                end
                PARITY: begin
                    error_nxt_s = (data_in != acc_r);
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Parser state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            len_r   <= 6'd0;
            acc_r   <= 8'h00;
            error_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            len_r   <= len_nxt_s;
            acc_r   <= acc_nxt_s;
            error_r <= error_nxt_s;
        end
    end

    router_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept_s),
        .wr_data (data_in),
        .pop     (read_enb),
        .rd_data (data_out),
        .full    (full_s),
        .empty   (empty_s)
    );

endmodule

// File: tb/tb_router_core.sv
// Directed bench for router_core: parsing, parity error flag, full/empty handling, reset.
module tb_router_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       pkt_valid = 1'b0;
    logic       read_enb = 1'b0;
    logic       busy;
    logic       error;
    logic [7:0] data_out;
    logic       valid_out;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] popq [$];
    logic       pop_seen = 1'b0;
    logic [7:0] pkt [20];

    always #5 clk = ~clk;

    router_core #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .busy      (busy),
        .error     (error),
        .read_enb  (read_enb),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    // Record every byte the reader actually pops, as seen on data_out after the edge.
    always @(posedge clk) pop_seen <= read_enb && valid_out && !rst;
    always @(negedge clk) if (pop_seen) popq.push_back(data_out);

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        data_in = b;
        pkt_valid = 1'b1;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: busy=%b after %0d cycles, required 0", busy, guard);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int n);
        @(negedge clk);
        pkt_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, error, valid_out, data_out} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b error=%b valid_out=%b data_out=%h, required all 0",
                     busy, error, valid_out, data_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_good_packet;
        logic [7:0] exp [5];
        exp = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        @(negedge clk);
        read_enb = 1'b1;
        popq.delete();
        // 0C^11^22^33 = 0C
        for (int i = 0; i < 5; i++) send_byte(exp[i]);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL good_error: error=%b, required 0", error);
        end
        idle_wait(4);
        vectors++;
        if (popq.size() != 5) begin
            miscompares++;
            $display("FAIL good_count: popped %0d bytes, required 5", popq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (popq[i] !== exp[i]) begin
                    miscompares++;
                    $display("FAIL good_data[%0d]: got %h, required %h", i, popq[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_bad_packet;
        popq.delete();
        send_byte(8'h0C); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h00);
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_error_set: error=%b, required 1", error);
        end
        send_byte(8'h0C);
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_error_hold: error=%b, required 1", error);
        end
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h0C);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_error_clear: error=%b, required 0", error);
        end
        idle_wait(4);
        vectors++;
        if (popq.size() != 10) begin
            miscompares++;
            $display("FAIL bad_count: popped %0d bytes, required 10", popq.size());
        end
    endtask

    task automatic test_zero_len;
        popq.delete();
        send_byte(8'h01);
        send_byte(8'h01);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_error: error=%b, required 0", error);
        end
        idle_wait(4);
        vectors++;
        if (popq.size() != 2 || popq[0] !== 8'h01 || popq[1] !== 8'h01) begin
            miscompares++;
            $display("FAIL zero_len_data: popped %0d bytes, required 2 bytes 01 01", popq.size());
        end
    endtask

    task automatic test_fill;
        logic [7:0] par;
        pkt[0] = 8'h48;
        par = pkt[0];
        for (int i = 1; i < 19; i++) begin
            pkt[i] = 8'(i * 7 + 3);
            par = par ^ pkt[i];
        end
        pkt[19] = par;
        @(negedge clk);
        read_enb = 1'b0;
        popq.delete();
        for (int i = 0; i < 15; i++) send_byte(pkt[i]);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_15_busy: busy=%b, required 0", busy);
        end
        send_byte(pkt[15]);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_16_busy: busy=%b, required 1", busy);
        end
        @(negedge clk);
        data_in = pkt[16];
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_held: busy=%b valid_out=%b, required 1 1", busy, valid_out);
        end
        read_enb = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_pop_clears_busy: busy=%b, required 0", busy);
        end
        @(negedge clk);
        read_enb = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_one_more_in: busy=%b, required 1", busy);
        end
        read_enb = 1'b1;
        for (int i = 17; i < 20; i++) send_byte(pkt[i]);
        idle_wait(25);
        vectors++;
        if (popq.size() != 20) begin
            miscompares++;
            $display("FAIL fill_drain_count: popped %0d bytes, required 20", popq.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                vectors++;
                if (popq[i] !== pkt[i]) begin
                    miscompares++;
                    $display("FAIL fill_drain[%0d]: got %h, required %h", i, popq[i], pkt[i]);
                end
            end
        end
        vectors++;
        if (error !== 1'b0 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_end: error=%b valid_out=%b, required 0 0", error, valid_out);
        end
    endtask

    task automatic test_reset_mid_packet;
        @(negedge clk);
        read_enb = 1'b0;
        send_byte(8'h01);
        send_byte(8'hFF);
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_error: error=%b, required 1", error);
        end
        send_byte(8'h08);
        send_byte(8'h55);
        @(negedge clk);
        pkt_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, error, valid_out, data_out} !== 11'h000) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: busy=%b error=%b valid_out=%b data_out=%h, required all 0",
                     busy, error, valid_out, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        read_enb = 1'b1;
        popq.delete();
        send_byte(8'h04); send_byte(8'hAB); send_byte(8'hAF);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_fresh_error: error=%b, required 0", error);
        end
        idle_wait(4);
        vectors++;
        if (popq.size() != 3 || popq[0] !== 8'h04 || popq[1] !== 8'hAB || popq[2] !== 8'hAF) begin
            miscompares++;
            $display("FAIL rst_fresh_data: popped %0d bytes, required 3 bytes 04 AB AF", popq.size());
        end
    endtask

    task automatic test_empty_read;
        read_enb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== 8'hAF || valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL empty_read[%0d]: data_out=%h valid_out=%b, required AF 0",
                         i, data_out, valid_out);
            end
        end
        read_enb = 1'b0;
    endtask

    initial begin
        test_reset;
        test_good_packet;
        test_bad_packet;
        test_zero_len;
        test_fill;
        test_reset_mid_packet;
        test_empty_read;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
